// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: BCD real-time clock behind a multiplexed 8-bit
// address/data bus with active-low strobes.
//
// Ports
//   clk       : single clock, all state changes on the rising edge
//   reset     : synchronous, active-low
//   a_d       : bus phase select (0 = address phase, 1 = data phase)
//   cs        : chip select, active-low
//   rd        : read strobe, active-low
//   wr        : write strobe, active-low
//   dato      : bidirectional address/data bus, high-Z unless reading
//   tick_1hz  : one-cycle pulse on each prescaler terminal count
//
// Register map: 0x00 control (bit0 halt), 0x21..0x26 seconds, minutes,
// hours, day, month, year (BCD). Other addresses read 0x00, writes ignored.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_d,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  inout  wire  [7:0] dato,
  output logic       tick_1hz
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_YEAR = 8'h26;

  // Time fields, index 0 = seconds ... 5 = year.
  localparam logic [7:0] FMIN [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  localparam logic [7:0] FMAX [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

  logic          a_d_q, cs_q, rd_q, wr_q;
  logic          rd_prev, wr_prev;
  logic [7:0]    addr;
  logic [7:0]    hold;
  logic          halt;
  logic [7:0]    tf      [6];
  logic [7:0]    tf_next [6];
  logic [PW-1:0] presc;

  logic          wr_rise, rd_fall;
  logic          addr_wr, data_wr, rd_cap;
  logic          tc;
  logic [7:0]    rd_data;
  logic          carry;
  logic          we;
  logic [8:0]    step;

  // Returns {wrap, next}; any raw value at or above max wraps to min.
  function automatic logic [8:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v >= hi)
      return {1'b1, lo};
    else if (v[3:0] >= 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v + 8'd1};
  endfunction

  // Edges use the registered copies; a strobe edge while the other strobe is
  // low (or moving) is treated as a bus conflict and ignored.
  always_comb begin
    wr_rise = wr_q & ~wr_prev & rd_q & rd_prev;
    rd_fall = ~rd_q & rd_prev & wr_q & wr_prev;
    addr_wr = wr_rise & ~cs_q & ~a_d_q;
    data_wr = wr_rise & ~cs_q & a_d_q;
    rd_cap  = rd_fall & ~cs_q & a_d_q;
    tc      = (presc == PRESC_LAST);
  end

  // Ripple-carry time chain; a bus write to a field wins over the tick and
  // stops the carry at that field.
  always_comb begin
    carry = tc & ~halt;
    we    = 1'b0;
    step  = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      step       = bcd_step(tf[i], FMIN[i], FMAX[i]);
      we         = data_wr && (addr == ADDR_SEC + 8'(i));
      tf_next[i] = we ? dato : (carry ? step[7:0] : tf[i]);
      carry      = carry & step[8] & ~we;
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_CTRL)
      rd_data = {7'b0, halt};
    else if (addr >= ADDR_SEC && addr <= ADDR_YEAR)
      rd_data = tf[addr[2:0] - 3'd1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_d_q    <= 1'b1;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      rd_prev  <= 1'b1;
      wr_prev  <= 1'b1;
      addr     <= '0;
      hold     <= '0;
      halt     <= 1'b0;
      presc    <= '0;
      tick_1hz <= 1'b0;
      for (int unsigned i = 0; i < 6; i++)
        tf[i] <= FMIN[i];
    end else begin
      a_d_q   <= a_d;
      cs_q    <= cs;
      rd_q    <= rd;
      wr_q    <= wr;
      rd_prev <= rd_q;
      wr_prev <= wr_q;

      if (addr_wr)
        addr <= dato;
      if (data_wr && addr == ADDR_CTRL)
        halt <= dato[0];
      for (int unsigned i = 0; i < 6; i++)
        tf[i] <= tf_next[i];
      if (rd_cap)
        hold <= rd_data;

      // Writing seconds restarts the prescaler so a full second follows.
      if (tc || (data_wr && addr == ADDR_SEC))
        presc <= '0;
      else
        presc <= presc + 1'b1;
      tick_1hz <= tc;
    end
  end

  assign dato = (~cs_q & ~rd_q & a_d_q) ? hold : 8'bz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with TICK_DIV = 32. All bus tasks
// take a fixed number of cycles so tick timing is known exactly after each
// write to seconds (which restarts the prescaler).
module tb_rtc_bus_responder;

  localparam int unsigned DIV = 32;

  logic       clk = 1'b0;
  logic       reset, a_d, cs, rd, wr;
  logic [7:0] tb_drv;
  logic       tb_oe;
  wire  [7:0] dato;
  logic       tick_1hz;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_seen = 0;

  assign dato = tb_oe ? tb_drv : 8'bz;

  // Released bus reads back as 0xFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (dato[g]);
  end

  rtc_bus_responder #(.TICK_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_d      (a_d),
    .cs       (cs),
    .rd       (rd),
    .wr       (wr),
    .dato     (dato),
    .tick_1hz (tick_1hz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick_1hz) tick_seen++;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus phase ending in a wr rising edge; lasts 5 cycles.
  task automatic bus_phase(input logic phase, input logic [7:0] v, input logic csv);
    cs = csv; a_d = phase; tb_drv = v; tb_oe = 1'b1; wr = 1'b0;
    cyc(2);
    wr = 1'b1;
    cyc(2);
    cs = 1'b1; tb_oe = 1'b0;
    cyc(1);
  endtask

  // Write edge lands 9 cycles after start; lasts 10 cycles.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
    bus_phase(1'b0, a, 1'b0);
    bus_phase(1'b1, v, 1'b0);
  endtask

  // Capture edge lands 7 cycles after start; first sample at +8, second
  // sample after extra cycles, released-bus sample 2 cycles after rd rises.
  task automatic bus_read(input logic [7:0] a, input int unsigned extra,
                          output logic [7:0] first, output logic [7:0] last,
                          output logic [7:0] after);
    bus_phase(1'b0, a, 1'b0);
    cs = 1'b0; a_d = 1'b1; rd = 1'b0;
    cyc(3);
    first = dato;
    cyc(extra);
    last = dato;
    rd = 1'b1;
    cyc(2);
    after = dato;
    cs = 1'b1;
    cyc(1);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] f, l, r;
    bus_read(a, 0, f, l, r);
    check_eq(tag, f, exp);
  endtask

  initial begin
    logic [7:0] f, l, r;
    int unsigned t0;
    logic [7:0] exp_t [6];

    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; a_d = 1'b0;
    tb_drv = '0; tb_oe = 1'b0;
    cyc(3);
    check_eq("reset_tick", {7'b0, tick_1hz}, 8'h00);
    check_eq("reset_bus_z", dato, 8'hFF);
    reset = 1'b1;
    cyc(1);

    // Halt, then basic write/read and bus release.
    bus_write(8'h00, 8'h01);
    read_check("ctrl_halt", 8'h00, 8'h01);
    bus_write(8'h22, 8'h45);
    bus_read(8'h22, 0, f, l, r);
    check_eq("min_read", f, 8'h45);
    check_eq("min_read_release", r, 8'hFF);
    bus_write(8'h30, 8'h55);
    read_check("unmapped", 8'h30, 8'h00);
    bus_phase(1'b0, 8'h22, 1'b0);
    bus_phase(1'b1, 8'h11, 1'b1);
    read_check("cs_high_ignored", 8'h22, 8'h45);

    // Halted ticks are discarded but tick_1hz keeps pulsing.
    bus_write(8'h21, 8'h05);
    t0 = tick_seen;
    cyc(100);
    check_eq("halt_ticks", 8'(tick_seen - t0), 8'd3);
    read_check("halt_sec", 8'h21, 8'h05);
    bus_write(8'h21, 8'h05);
    bus_write(8'h00, 8'h00);
    cyc(21);
    bus_write(8'h00, 8'h01);
    read_check("unhalt_sec", 8'h21, 8'h06);

    // Write to seconds coincides with a tick at 0x59.
    bus_write(8'h21, 8'h59);
    bus_write(8'h00, 8'h00);
    cyc(12);
    bus_write(8'h21, 8'h30);
    bus_write(8'h00, 8'h01);
    read_check("wr_prio_sec", 8'h21, 8'h30);
    read_check("wr_prio_min", 8'h22, 8'h45);

    // Full rollover 23:59:59 31/12/99.
    bus_write(8'h22, 8'h59);
    bus_write(8'h23, 8'h23);
    bus_write(8'h24, 8'h31);
    bus_write(8'h25, 8'h12);
    bus_write(8'h26, 8'h99);
    bus_write(8'h21, 8'h59);
    bus_write(8'h00, 8'h00);
    cyc(21);
    check_eq("roll_tick", {7'b0, tick_1hz}, 8'h01);
    bus_write(8'h00, 8'h01);
    exp_t = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    for (int i = 0; i < 6; i++) begin
      bus_read(8'h21 + 8'(i), 0, f, l, r);
      check_eq($sformatf("roll_%02h", 8'h21 + 8'(i)), f, exp_t[i]);
    end

    // Read-hold spanning a tick 0x09 -> 0x10.
    bus_write(8'h21, 8'h09);
    bus_write(8'h00, 8'h00);
    bus_read(8'h21, 20, f, l, r);
    check_eq("hold_early", f, 8'h09);
    check_eq("hold_late", l, 8'h09);
    check_eq("hold_release", r, 8'hFF);
    bus_write(8'h00, 8'h01);
    read_check("bcd_carry", 8'h21, 8'h10);

    // Reset in the middle of a data-phase write to hours.
    bus_write(8'h23, 8'h12);
    bus_write(8'h24, 8'h15);
    read_check("hours_pre", 8'h23, 8'h12);
    bus_phase(1'b0, 8'h23, 1'b0);
    cs = 1'b0; a_d = 1'b1; tb_drv = 8'h77; tb_oe = 1'b1; wr = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    wr = 1'b1; cs = 1'b1; tb_oe = 1'b0;
    cyc(1);
    check_eq("rst_bus_z", dato, 8'hFF);
    check_eq("rst_tick", {7'b0, tick_1hz}, 8'h00);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    read_check("rst_hours", 8'h23, 8'h00);
    read_check("rst_day", 8'h24, 8'h01);
    read_check("rst_ctrl", 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
